// File: rtl/coeff_bank_writer.sv
// rtl/coeff_bank_writer.sv - banked FIR coefficient store with CPU write port and per-sample bank switch
module coeff_bank_writer #(
    parameter int NUM_TAPS  = 16,
    parameter int NUM_BANKS = 4,
    parameter int COEFF_W   = 16
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic [8:0]         update_control,
    input  logic [COEFF_W-1:0] update_value,
    input  logic [1:0]         x_coeff_bank,
    input  logic [1:0]         y_coeff_bank,
    input  logic [1:0]         z_coeff_bank,
    input  logic               sample_start,
    input  logic [3:0]         tap_addr,
    input  logic               err_clear,
    output logic [COEFF_W-1:0] x_coeff,
    output logic [COEFF_W-1:0] y_coeff,
    output logic [COEFF_W-1:0] z_coeff,
    output logic               write_ack,
    output logic               write_err
);

    localparam int NUM_AXES = 3;

    // Coefficient store, one bank set per axis; flops so reset clears it
    logic [COEFF_W-1:0] store_q [NUM_AXES][NUM_BANKS][NUM_TAPS];
    logic [COEFF_W-1:0] store_d [NUM_AXES][NUM_BANKS][NUM_TAPS];

    // Active bank per axis and the registered read data
    logic [1:0]         act_q   [NUM_AXES];
    logic [1:0]         act_d   [NUM_AXES];
    logic [COEFF_W-1:0] coeff_q [NUM_AXES];
    logic [COEFF_W-1:0] coeff_d [NUM_AXES];

    // Strobe history and the write captured in the event cycle
    logic               strb_q, strb_d;
    logic               wr_en_q, wr_en_d;
    logic [1:0]         wr_axis_q, wr_axis_d;
    logic [1:0]         wr_bank_q, wr_bank_d;
    logic [3:0]         wr_tap_q, wr_tap_d;
    logic [COEFF_W-1:0] wr_val_q, wr_val_d;
    logic               err_q, err_d;

    logic [1:0] bank_req [NUM_AXES];
    logic [1:0] eff      [NUM_AXES];
    logic       write_event;
    logic       reject;
    logic [1:0] ev_axis;
    logic [1:0] ev_bank;

    assign bank_req[0] = x_coeff_bank;
    assign bank_req[1] = y_coeff_bank;
    assign bank_req[2] = z_coeff_bank;

    assign ev_axis     = update_control[7:6];
    assign ev_bank     = update_control[5:4];
    assign write_event = update_control[8] & ~strb_q;

    // Next-state: effective bank, write qualification, bank switch, read and store update
    always_comb begin
        strb_d    = update_control[8];
        reject    = 1'b0;
        wr_en_d   = 1'b0;
        wr_axis_d = wr_axis_q;
        wr_bank_d = wr_bank_q;
        wr_tap_d  = wr_tap_q;
        wr_val_d  = wr_val_q;
        store_d   = store_q;

        for (int a = 0; a < NUM_AXES; a++) begin
            // The bank being switched in this cycle already counts as active
            eff[a]     = sample_start ? bank_req[a] : act_q[a];
            act_d[a]   = sample_start ? bank_req[a] : act_q[a];
            // Read uses the store before this cycle's commit lands
            coeff_d[a] = store_q[a][eff[a]][tap_addr];
        end

        // Axis 3 is reserved; the active bank is never writable
        if (ev_axis == 2'd3) begin
            reject = 1'b1;
        end else begin
            for (int a = 0; a < NUM_AXES; a++) begin
                if (ev_axis == 2'(a) && ev_bank == eff[a]) begin
                    reject = 1'b1;
                end
            end
        end

        if (write_event) begin
            wr_en_d   = ~reject;
            wr_axis_d = ev_axis;
            wr_bank_d = ev_bank;
            wr_tap_d  = update_control[3:0];
            wr_val_d  = update_value;
        end

        // A rejection arriving with err_clear wins so it is never lost
        err_d = (write_event & reject) | (err_q & ~err_clear);

        if (wr_en_q) begin
            for (int a = 0; a < NUM_AXES; a++) begin
                if (wr_axis_q == 2'(a)) begin
                    store_d[a][wr_bank_q][wr_tap_q] = wr_val_q;
                end
            end
        end
    end

    // State registers; strobe history resets high so a held strobe is not a write
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            strb_q    <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_axis_q <= 2'd0;
            wr_bank_q <= 2'd0;
            wr_tap_q  <= 4'd0;
            wr_val_q  <= '0;
            err_q     <= 1'b0;
            for (int a = 0; a < NUM_AXES; a++) begin
                act_q[a]   <= 2'd0;
                coeff_q[a] <= '0;
                for (int b = 0; b < NUM_BANKS; b++) begin
                    for (int t = 0; t < NUM_TAPS; t++) begin
                        store_q[a][b][t] <= '0;
                    end
                end
            end
        end else begin
            strb_q    <= strb_d;
            wr_en_q   <= wr_en_d;
            wr_axis_q <= wr_axis_d;
            wr_bank_q <= wr_bank_d;
            wr_tap_q  <= wr_tap_d;
            wr_val_q  <= wr_val_d;
            err_q     <= err_d;
            act_q     <= act_d;
            coeff_q   <= coeff_d;
            store_q   <= store_d;
        end
    end

    assign x_coeff   = coeff_q[0];
    assign y_coeff   = coeff_q[1];
    assign z_coeff   = coeff_q[2];
    assign write_ack = wr_en_q;
    assign write_err = err_q;

endmodule

// File: tb/tb_coeff_bank_writer.sv
// tb/tb_coeff_bank_writer.sv - directed bench with behavioural model for coeff_bank_writer
module tb_coeff_bank_writer;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [8:0]  update_control;
    logic [15:0] update_value;
    logic [1:0]  x_coeff_bank, y_coeff_bank, z_coeff_bank;
    logic        sample_start;
    logic [3:0]  tap_addr;
    logic        err_clear;
    logic [15:0] x_coeff, y_coeff, z_coeff;
    logic        write_ack, write_err;

    int tests = 0;
    int fails = 0;
    int ack_cnt = 0;

    coeff_bank_writer dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .update_control (update_control),
        .update_value   (update_value),
        .x_coeff_bank   (x_coeff_bank),
        .y_coeff_bank   (y_coeff_bank),
        .z_coeff_bank   (z_coeff_bank),
        .sample_start   (sample_start),
        .tap_addr       (tap_addr),
        .err_clear      (err_clear),
        .x_coeff        (x_coeff),
        .y_coeff        (y_coeff),
        .z_coeff        (z_coeff),
        .write_ack      (write_ack),
        .write_err      (write_err)
    );

    always #5 clk_clk = ~clk_clk;

    // Behavioural model: coefficient memory, active banks, one pending write
    logic [15:0] m_store [3][4][16];
    logic [1:0]  m_act [3];
    logic        m_strb;
    logic        m_pend;
    int          m_pa, m_pb, m_pt;
    logic [15:0] m_pv;
    logic [15:0] exp_coeff [3];
    logic        exp_ack, exp_err;

    task automatic m_reset();
        for (int a = 0; a < 3; a++) begin
            m_act[a] = 2'd0;
            exp_coeff[a] = 16'h0;
            for (int b = 0; b < 4; b++)
                for (int t = 0; t < 16; t++)
                    m_store[a][b][t] = 16'h0;
        end
        m_strb = 1'b1;
        m_pend = 1'b0;
        exp_ack = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic m_step();
        logic [1:0] req [3];
        int eff [3];
        int ax, bk;
        logic ev, ok;
        req[0] = x_coeff_bank;
        req[1] = y_coeff_bank;
        req[2] = z_coeff_bank;
        for (int a = 0; a < 3; a++) begin
            eff[a] = sample_start ? int'(req[a]) : int'(m_act[a]);
            exp_coeff[a] = m_store[a][eff[a]][tap_addr];
        end
        if (m_pend) m_store[m_pa][m_pb][m_pt] = m_pv;
        ev = update_control[8] && !m_strb;
        m_strb = update_control[8];
        ax = int'(update_control[7:6]);
        bk = int'(update_control[5:4]);
        ok = (ax < 3) && (bk != eff[ax < 3 ? ax : 0]);
        exp_err = (ev && !ok) || (exp_err && !err_clear);
        exp_ack = ev && ok;
        m_pend = exp_ack;
        if (ev) begin
            m_pa = ax;
            m_pb = bk;
            m_pt = int'(update_control[3:0]);
            m_pv = update_value;
        end
        if (sample_start)
            for (int a = 0; a < 3; a++) m_act[a] = req[a];
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk_clk);
            if (!reset_reset_n) m_reset();
            else m_step();
        end
    end

    initial forever begin
        @(negedge reset_reset_n);
        m_reset();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    initial forever begin
        @(negedge clk_clk);
        chk("x_coeff", 32'(x_coeff), 32'(exp_coeff[0]));
        chk("y_coeff", 32'(y_coeff), 32'(exp_coeff[1]));
        chk("z_coeff", 32'(z_coeff), 32'(exp_coeff[2]));
        chk("write_ack", 32'(write_ack), 32'(exp_ack));
        chk("write_err", 32'(write_err), 32'(exp_err));
        if (write_ack === 1'b1) ack_cnt++;
    end

    task automatic cyc();
        @(negedge clk_clk);
        #1;
    endtask

    task automatic do_write(input int axis, input int bank, input int tap,
                            input logic [15:0] val, input int hold);
        update_control = {1'b1, 2'(axis), 2'(bank), 4'(tap)};
        update_value = val;
        repeat (hold) cyc();
        update_control[8] = 1'b0;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset_reset_n = 1'b0;
        update_control = 9'h100;
        update_value = 16'h0;
        x_coeff_bank = 2'd0;
        y_coeff_bank = 2'd0;
        z_coeff_bank = 2'd0;
        sample_start = 1'b0;
        tap_addr = 4'd0;
        err_clear = 1'b0;
        repeat (3) cyc();
        reset_reset_n = 1'b1;

        // Strobe high across reset release: no write
        repeat (3) begin
            cyc();
            chk("held_strobe_no_ack", 32'(write_ack), 32'h0);
        end
        chk("reset_x_coeff", 32'(x_coeff), 32'h0);
        update_control[8] = 1'b0;
        cyc();
        update_control = {1'b1, 2'd0, 2'd1, 4'd0};
        update_value = 16'h0007;
        cyc();
        chk("first_edge_ack", 32'(write_ack), 32'h1);
        update_control[8] = 1'b0;
        cyc();
        chk("ack_one_cycle", 32'(write_ack), 32'h0);

        // Long strobe gives one write; bank select needs sample_start
        base = ack_cnt;
        do_write(0, 1, 5, 16'h1234, 5);
        chk("held5_single_ack", 32'(ack_cnt - base), 32'h1);
        tap_addr = 4'd5;
        x_coeff_bank = 2'd1;
        repeat (2) cyc();
        chk("no_switch_x", 32'(x_coeff), 32'h0);
        sample_start = 1'b1;
        cyc();
        sample_start = 1'b0;
        chk("switch_x_1234", 32'(x_coeff), 32'h1234);

        // Rejections and err_clear
        base = ack_cnt;
        do_write(1, 0, 0, 16'h1111, 1);
        chk("active_bank_err", 32'(write_err), 32'h1);
        chk("active_bank_noack", 32'(ack_cnt - base), 32'h0);
        err_clear = 1'b1;
        cyc();
        err_clear = 1'b0;
        chk("err_cleared", 32'(write_err), 32'h0);
        do_write(3, 2, 0, 16'h3333, 1);
        chk("axis3_err", 32'(write_err), 32'h1);
        update_control = {1'b1, 2'd3, 2'd1, 4'd0};
        err_clear = 1'b1;
        cyc();
        update_control[8] = 1'b0;
        chk("clear_vs_reject", 32'(write_err), 32'h1);
        cyc();
        err_clear = 1'b0;
        chk("clear_after", 32'(write_err), 32'h0);

        // Bank switching in the event cycle makes the target active
        y_coeff_bank = 2'd2;
        sample_start = 1'b1;
        update_control = {1'b1, 2'd1, 2'd2, 4'd1};
        update_value = 16'h2222;
        cyc();
        sample_start = 1'b0;
        update_control[8] = 1'b0;
        chk("ss_same_cycle_err", 32'(write_err), 32'h1);
        err_clear = 1'b1;
        cyc();
        err_clear = 1'b0;
        update_control[8] = 1'b1;
        cyc();
        update_control[8] = 1'b0;
        cyc();
        chk("act_y2_err", 32'(write_err), 32'h1);
        err_clear = 1'b1;
        cyc();
        err_clear = 1'b0;

        // Read-before-write on the same z bank/tap
        base = ack_cnt;
        z_coeff_bank = 2'd3;
        tap_addr = 4'd15;
        update_control = {1'b1, 2'd2, 2'd3, 4'd15};
        update_value = 16'h8000;
        cyc();
        update_control[8] = 1'b0;
        sample_start = 1'b1;
        cyc();
        sample_start = 1'b0;
        chk("z_old_value", 32'(z_coeff), 32'h0);
        chk("z_ack", 32'(ack_cnt - base), 32'h1);
        cyc();
        chk("z_new_value", 32'(z_coeff), 32'h8000);

        // Reset between event and commit discards the write
        base = ack_cnt;
        update_control = {1'b1, 2'd0, 2'd2, 4'd3};
        update_value = 16'hBEEF;
        @(posedge clk_clk);
        #1;
        reset_reset_n = 1'b0;
        update_control = 9'h0;
        x_coeff_bank = 2'd0;
        y_coeff_bank = 2'd0;
        z_coeff_bank = 2'd0;
        repeat (2) cyc();
        reset_reset_n = 1'b1;
        cyc();
        chk("rst_no_ack", 32'(ack_cnt - base), 32'h0);
        chk("rst_z_zero", 32'(z_coeff), 32'h0);
        chk("rst_err_zero", 32'(write_err), 32'h0);
        do_write(0, 0, 4, 16'h0ABC, 1);
        chk("rst_act_x0", 32'(write_err), 32'h1);
        err_clear = 1'b1;
        cyc();
        err_clear = 1'b0;
        do_write(0, 2, 4, 16'h0777, 1);
        x_coeff_bank = 2'd2;
        tap_addr = 4'd3;
        sample_start = 1'b1;
        cyc();
        sample_start = 1'b0;
        chk("rst_discarded", 32'(x_coeff), 32'h0);
        tap_addr = 4'd4;
        cyc();
        chk("post_rst_write", 32'(x_coeff), 32'h0777);

        repeat (2) cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/coeff_bank_writer.md
Name: coeff_bank_writer

Overview:
- Downstream of the Nios II CPU system. Consumes its update_control / update_value PIO exports and its x/y/z coeff-bank selects.
- Holds the FIR coefficient store for the three accelerometer axes, 4 banks × 16 taps per axis.
- Software writes single coefficients into inactive banks. The filter datapath reads one tap per axis per cycle from the active bank.
- Active bank per axis changes only at a sample boundary, so a filter pass never mixes banks.

Parameters:
- NUM_TAPS, 16, taps per bank; tap index 4 bits.
- NUM_BANKS, 4, banks per axis; bank index 2 bits.
- COEFF_W, 16, coefficient width, two's complement.

Ports:
- clk_clk  in  1  system clock, same domain as CPU PIOs.
- reset_reset_n  in  1  asynchronous, active-low reset.
- update_control  in  9  [8]=write strobe, [7:6]=axis (0=x, 1=y, 2=z, 3=reserved), [5:4]=bank, [3:0]=tap.
- update_value  in  COEFF_W  coefficient to write.
- x_coeff_bank  in  2  requested active bank, x axis.
- y_coeff_bank  in  2  requested active bank, y axis.
- z_coeff_bank  in  2  requested active bank, z axis.
- sample_start  in  1  1-cycle pulse from the filter at the start of each sample pass.
- tap_addr  in  4  tap read index, shared by all axes.
- err_clear  in  1  clears write_err.
- x_coeff  out  COEFF_W  registered x coefficient.
- y_coeff  out  COEFF_W  registered y coefficient.
- z_coeff  out  COEFF_W  registered z coefficient.
- write_ack  out  1  1-cycle pulse when a write commits.
- write_err  out  1  sticky flag: a write was rejected.

Behaviour:
- Reset (async assert, sync deassert):
  - all coefficients = 0; act_x/act_y/act_z = 0
  - x/y/z_coeff = 0; write_ack = 0; write_err = 0
  - strobe history register = 1, so a strobe already high at reset release causes no write
  - a pending write is discarded
- Write detect:
  - strb_q <= update_control[8] every cycle.
  - Write event = update_control[8] & ~strb_q (rising edge). Axis, bank, tap and update_value are captured in that cycle.
  - Holding the strobe high yields exactly one write. Software must drop the strobe before the next write.
- Commit, one cycle after the event:
  - Store written, write_ack = 1 for exactly that cycle.
  - Effective active bank, per axis: eff = sample_start ? *_coeff_bank : act_*.
  - Reject if axis == 3, or if bank == eff bank of the target axis in the event cycle.
  - Rejected write: no store change, no ack, write_err = 1 in the commit cycle.
- write_err:
  - Stays set until err_clear.
  - A new rejection in the same cycle as err_clear leaves write_err = 1.
- Bank switch:
  - On sample_start: act_* <= *_coeff_bank.
  - Bank select changes without sample_start have no effect on reads.
- Read:
  - *_coeff <= store[axis][eff][tap_addr] every cycle; 1-cycle latency.
  - Read in the sample_start cycle uses the new bank.
- Simultaneous read and commit to the same axis/bank/tap: read returns the old value (read-before-write). The new value is visible from the following read.
- Writes never target the active bank, so an in-progress filter pass sees a stable bank.
- Back-to-back writes: minimum strobe period is 2 cycles (high, low). Each event commits independently.
- Store is flop-based, reset to 0. No RAM inference: it would lose the reset-to-zero guarantee.

Test Plan:
- Reset release with update_control[8] = 1 → no write_ack, all outputs 0. Drop then raise strobe → one write_ack.
- Active banks 0. Write axis 0, bank 1, tap 5, value 0x1234, strobe held 5 cycles → single write_ack one cycle after the edge. tap_addr = 5 with x_coeff_bank = 1 and no sample_start → x_coeff stays 0. Pulse sample_start → x_coeff = 0x1234 on the next cycle.
- Write axis 1, bank 0 (active bank 0) → no ack, write_err = 1. Assert err_clear → write_err = 0. Write axis 3, any bank → write_err = 1.
- With sample_start = 1 and y_coeff_bank = 2 in the event cycle, write axis 1, bank 2 → rejected, write_err = 1. The same write one cycle later, with act_y = 2 → still rejected.
- Write z bank 3 tap 15 = 0x8000 while the filter reads z bank 3 tap 15 in the commit cycle (act_z = 3 via a direct sample_start after the write event) → read returns the old 0x0000, next read returns 0x8000.
- Assert reset_reset_n = 0 in the cycle between the write event and commit → no ack, store unchanged. After release, all outputs 0 and act banks 0.
